// File: rtl/core_pkg.sv
// Shared decode/ALU type definitions: the ALU operation encoding.
package core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLTS = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIVU = 4'd11,
    ALU_REMU = 4'd12
  } alu_opcode_e;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between decode (master) and the multi-cycle ALU (slave).
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  import core_pkg::*;

  logic             alu_flush_ip;
  logic             alu_enable_ip;
  alu_opcode_e      alu_operator_ip;
  logic [WIDTH-1:0] alu_operand_a_ip;
  logic [WIDTH-1:0] alu_operand_b_ip;
  logic             alu_ready_op;
  logic [WIDTH-1:0] alu_result_op;
  logic             alu_valid_op;
  logic             alu_error_op;

  modport master (
    output alu_flush_ip, alu_enable_ip, alu_operator_ip, alu_operand_a_ip, alu_operand_b_ip,
    input  alu_ready_op, alu_result_op, alu_valid_op, alu_error_op
  );

  modport slave (
    input  alu_flush_ip, alu_enable_ip, alu_operator_ip, alu_operand_a_ip, alu_operand_b_ip,
    output alu_ready_op, alu_result_op, alu_valid_op, alu_error_op
  );

endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops with one registered cycle, iterative MUL/DIVU/REMU in WIDTH+1 cycles.
// Define ALU_DIV_EN to build the restoring divider; otherwise DIVU/REMU complete as unsupported.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  alu_mc_if.slave bus
);
  import core_pkg::*;

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_e;

  state_e           state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r;
  alu_opcode_e      op_r;
  logic [WIDTH-1:0] acc_r, a_r, b_r;
  logic [WIDTH-1:0] acc_nxt_s, a_nxt_s, b_nxt_s;
  logic [WIDTH-1:0] result_r, single_res_s, iter_res_s;
  logic             valid_r, error_r;
  logic             ready_s, accept_s, is_iter_s, single_err_s;
  logic [SHW-1:0]   shamt_s;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   div_shift_s, div_diff_s;
`endif

  assign accept_s           = bus.alu_enable_ip && ready_s && !bus.alu_flush_ip;
  assign bus.alu_ready_op   = ready_s;
  assign bus.alu_result_op  = result_r;
  assign bus.alu_valid_op   = valid_r;
  assign bus.alu_error_op   = error_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Flush overrides every transition, including an acceptance in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.alu_flush_ip) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: if (accept_s && is_iter_s) state_nxt_s = ITER; else state_nxt_s = IDLE;
        ITER:       if (cnt_r == {CW{1'b0}}) state_nxt_s = DONE; else state_nxt_s = ITER;
        default:    state_nxt_s = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_s = 1'b1;
    case (state_r)
      ITER:    ready_s = 1'b0;
      default: ready_s = 1'b1;
    endcase
  end

  always_comb begin
    single_res_s = {WIDTH{1'b0}};
    single_err_s = 1'b0;
    is_iter_s    = 1'b0;
    shamt_s      = bus.alu_operand_b_ip[SHW-1:0];
    case (bus.alu_operator_ip)
      ALU_ADD:  single_res_s = bus.alu_operand_a_ip + bus.alu_operand_b_ip;
      ALU_SUB:  single_res_s = bus.alu_operand_a_ip - bus.alu_operand_b_ip;
      ALU_SLTS: single_res_s = {{(WIDTH-1){1'b0}},
                                ($signed(bus.alu_operand_a_ip) < $signed(bus.alu_operand_b_ip))};
      ALU_SLTU: single_res_s = {{(WIDTH-1){1'b0}}, (bus.alu_operand_a_ip < bus.alu_operand_b_ip)};
      ALU_AND:  single_res_s = bus.alu_operand_a_ip & bus.alu_operand_b_ip;
      ALU_OR:   single_res_s = bus.alu_operand_a_ip | bus.alu_operand_b_ip;
      ALU_XOR:  single_res_s = bus.alu_operand_a_ip ^ bus.alu_operand_b_ip;
      ALU_SLL:  single_res_s = bus.alu_operand_a_ip << shamt_s;
      ALU_SRL:  single_res_s = bus.alu_operand_a_ip >> shamt_s;
      ALU_SRA:  single_res_s = $signed(bus.alu_operand_a_ip) >>> shamt_s;
      ALU_MUL:  is_iter_s = 1'b1;
`ifdef ALU_DIV_EN
      ALU_DIVU, ALU_REMU: is_iter_s = 1'b1;
`else
      ALU_DIVU, ALU_REMU: single_err_s = 1'b1;
`endif
      default:  single_err_s = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply, or restoring divide with acc_r as remainder
  // and a_r collecting quotient bits. A zero divisor naturally yields all-ones / operand A.
  always_comb begin
    acc_nxt_s = acc_r;
    a_nxt_s   = {a_r[WIDTH-2:0], 1'b0};
    b_nxt_s   = {1'b0, b_r[WIDTH-1:1]};
    iter_res_s = acc_r;
`ifdef ALU_DIV_EN
    div_shift_s = {acc_r, a_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    if (op_r == ALU_DIVU || op_r == ALU_REMU) begin
      b_nxt_s = b_r;
      if (!div_diff_s[WIDTH]) begin
        acc_nxt_s = div_diff_s[WIDTH-1:0];
        a_nxt_s   = {a_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt_s = div_shift_s[WIDTH-1:0];
        a_nxt_s   = {a_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (b_r[0]) acc_nxt_s = acc_r + a_r;
      else        acc_nxt_s = acc_r;
    end
    if (op_r == ALU_DIVU) iter_res_s = a_r;
    else                  iter_res_s = acc_r;
`else
    if (b_r[0]) acc_nxt_s = acc_r + a_r;
    else        acc_nxt_s = acc_r;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= {CW{1'b0}};
      op_r     <= ALU_ADD;
      acc_r    <= {WIDTH{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
      error_r  <= 1'b0;
    end else if (bus.alu_flush_ip) begin
      cnt_r   <= {CW{1'b0}};
      valid_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      case (state_r)
        ITER: begin
          if (cnt_r != {CW{1'b0}}) begin
            acc_r   <= acc_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            cnt_r   <= cnt_r - CW'(1);
            valid_r <= 1'b0;
            error_r <= 1'b0;
          end else begin
            result_r <= iter_res_s;
            valid_r  <= 1'b1;
            error_r  <= 1'b0;
          end
        end
        default: begin
          valid_r <= 1'b0;
          error_r <= 1'b0;
          if (accept_s && is_iter_s) begin
            cnt_r <= CW'(WIDTH);
            op_r  <= bus.alu_operator_ip;
            acc_r <= {WIDTH{1'b0}};
            a_r   <= bus.alu_operand_a_ip;
            b_r   <= bus.alu_operand_b_ip;
          end else if (accept_s) begin
            result_r <= single_res_s;
            valid_r  <= 1'b1;
            error_r  <= single_err_s;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor to the core ALU. Sits between decode and LSU/MEM/fetch: accepts one operation per handshake, returns single-cycle ops with one cycle of registered latency and iterative multiply/divide ops after a fixed WIDTH+1 cycles. Adds unsigned compare, logic ops, shifts, an error flag and a flush input.

## Interface
- WIDTH, 32, datapath width. Must be a power of two and at least 8.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- alu_flush_ip  in  1  synchronous abort of the in-flight operation
- alu_enable_ip  in  1  request; operation is accepted when alu_enable_ip && alu_ready_op at a rising edge
- alu_operator_ip  in  alu_opcode_e  operation code (CORE_PKG): ALU_ADD, ALU_SUB, ALU_SLTS, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_DIVU, ALU_REMU
- alu_operand_a_ip  in  WIDTH  operand A
- alu_operand_b_ip  in  WIDTH  operand B
- alu_ready_op  out  1  block can accept an operation this cycle
- alu_result_op  out  WIDTH  registered result
- alu_valid_op  out  1  one-cycle pulse marking alu_result_op valid
- alu_error_op  out  1  qualifies alu_valid_op: the operation was unsupported

## Operation
- The FSM has three states: IDLE, ITER and DONE.
- IDLE accepts any op. A single-cycle op stays in IDLE and registers its result. ALU_MUL, ALU_DIVU and ALU_REMU go to ITER with the step counter set to WIDTH.
- ITER performs one step per cycle and decrements the counter. When the counter reaches 0 the FSM goes to DONE.
- DONE drives valid and returns to IDLE. A new op may be accepted in the DONE cycle.
- ADD/SUB wrap modulo 2^WIDTH.
- SLTS (signed compare) and SLTU (unsigned compare) return 1 or 0, zero-extended.
- Shift amount is operand_b[$clog2(WIDTH)-1:0]; the upper bits of operand_b are ignored. SRA replicates the MSB.
- MUL uses shift-add, one bit per step. It returns the low WIDTH bits of the product; this is identical for signed and unsigned operands.
- DIVU/REMU use restoring division, one quotient bit per step.
- Divide by zero still takes the full latency. DIVU returns all ones. REMU returns operand A.
- An unsupported opcode completes with single-cycle latency: result 0, valid 1, error 1.
- alu_error_op is 0 whenever alu_valid_op is 0.
- Operands and opcode are captured at acceptance. Inputs may change freely while the block is busy.
- Flush:
  - Returns the FSM to IDLE and suppresses any pending valid in the next cycle.
  - Flush wins over a simultaneous enable; that op is not accepted.
  - alu_result_op holds its previous value.

## Timing
- Reset values: alu_result_op = 0, alu_valid_op = 0, alu_error_op = 0, alu_ready_op = 1, FSM = IDLE, counter = 0.
- Reset asserted mid-operation aborts it immediately and asynchronously. No valid is produced for that op.
- Single-cycle op accepted at edge N:
  - valid/result are high in the cycle after edge N, for exactly one cycle.
  - alu_ready_op stays 1, so back-to-back ops give valid on consecutive cycles.
- Iterative op accepted at edge N:
  - alu_ready_op is low from edge N until edge N+WIDTH+1.
  - valid/result are high in the cycle after edge N+WIDTH+1 (latency WIDTH+1). alu_ready_op is 1 in that cycle.
- alu_ready_op is combinational from FSM state only. It does not depend on alu_enable_ip.
- alu_valid_op never stays high for more than one cycle per accepted op.

## Configuration
- Macro: ALU_DIV_EN.
- Defined: DIVU/REMU are built as described, sharing the iteration counter and FSM with MUL.
- Undefined: the divider datapath is removed. DIVU/REMU are treated as unsupported: 1-cycle latency, result 0, valid 1, error 1.

## Test plan
- Reset, then ADD 0xFFFFFFFF + 1 at edge N, WIDTH=32 -> result 0x0, valid in cycle after N, error 0, ready stays 1.
- Back-to-back SLTS(0xFFFFFFFF, 1), SLTU(0xFFFFFFFF, 1), SRA(0x80000000, 36) -> results 1, 0, 0xF8000000 on three consecutive valid cycles.
- MUL 0x0001_0003 × 0x0000_0005 at edge N -> ready low for 33 edges, result 0x0005_000F valid in cycle after N+33; enable held high meanwhile is ignored.
- With ALU_DIV_EN: DIVU 100/7 -> 14 and REMU 100/7 -> 2, latency 33 each; DIVU x/0 -> 0xFFFFFFFF and REMU 0x1234/0 -> 0x1234. Without ALU_DIV_EN: DIVU -> result 0 with error 1, latency 1.
- MUL accepted, flush at step 10 with enable high -> no valid and no new op accepted that cycle, ready 1 next cycle, a following ADD completes normally.
- Reset asserted mid-MUL -> all outputs immediately return to reset values, no stray valid after release.
